// File: rtl/main_control_fsm.sv
// main_control_fsm -- multicycle control unit for a small 16-bit datapath.
//
// Purpose:
//   Sequences each instruction through FETCH / DECODE / execute / writeback
//   states. It drives the datapath mux selects and write enables, counts
//   retired instructions, flags the illegal opcode, and stops in HALT.
//
// Configuration macro:
//   MEM_WAIT_EN -- when defined, adds FWAIT and MRDW for a synchronous memory
//                  with one cycle of read latency. When undefined, both
//                  states are unreachable.
//
// Ports:
//   clock, reset             rising-edge clock; asynchronous active-high reset
//   enable                   run/stall; low freezes state and counter
//   opcode[2:0]              IR[15:13] from the datapath
//   ALUOp, ALUSrcB, PCSource 2-bit ALU class / ALU B select / PC source
//   RegDst .. ALUSrcA        1-bit datapath controls
//   state[3:0]               current state code (debug)
//   halted                   high in HALT
//   illegal_op               sticky; set when opcode 110 is decoded
//   instr_retired[15:0]      completed-instruction count; wraps
//
// Handshake: this block has no valid/ready interfaces. enable acts as a
// level-sensitive stall qualifier. While enable is low, no state advances,
// and every side-effecting strobe (PCWrite, PCWriteCond, RegWrite, IRWrite,
// MemWrite, MemRead) is held at 0. The mux selects keep showing the current
// state's values.
module main_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  opcode,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        ALUSrcA,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,  S_FWAIT = 4'd1,  S_DECODE = 4'd2, S_MADDR = 4'd3,
    S_MRD   = 4'd4,  S_MRDW  = 4'd5,  S_MWB    = 4'd6, S_MWR   = 4'd7,
    S_REXE  = 4'd8,  S_RWB   = 4'd9,  S_BEQ    = 4'd10, S_JMP  = 4'd11,
    S_IEXE  = 4'd12, S_IWB   = 4'd13, S_HALT   = 4'd14
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       ior_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
  } ctrl_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_J    = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Full control word for each state. Anything not set here stays 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
`ifndef MEM_WAIT_EN
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
`endif
      end
      // IR capture and the PC+1 update wait for the read data to arrive.
      S_FWAIT: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MRD, S_MRDW: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.ior_d      = 1'b1;
        c.mem_read   = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_IWB:   c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    if (enable) begin
      case (state_q)
`ifdef MEM_WAIT_EN
        S_FETCH: state_d = S_FWAIT;
`else
        S_FETCH: state_d = S_DECODE;
`endif
        S_FWAIT: state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MADDR;
            OP_R:         state_d = S_REXE;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JMP;
            OP_ADDI:      state_d = S_IEXE;
            OP_HALT:      state_d = S_HALT;
            OP_ILL: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
            default:      state_d = S_FETCH;
          endcase
        end
        S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
`ifdef MEM_WAIT_EN
        S_MRD:   state_d = S_MRDW;
`else
        S_MRD:   state_d = S_MWB;
`endif
        S_MRDW:  state_d = S_MWB;
        S_MWB, S_MWR, S_RWB, S_BEQ, S_JMP, S_IWB: state_d = S_FETCH;
        S_REXE:  state_d = S_RWB;
        S_IEXE:  state_d = S_IWB;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
      // FETCH never loops on itself, so entering FETCH marks one retirement.
      if (state_d == S_FETCH) retired_d = retired_q + 16'd1;
    end
    ctrl_d   = decode_ctrl(state_d);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are gated by enable so that a stall has no side effects.
  // The registered word is left untouched, so on resume the state's full
  // output set appears again.
  assign ALUOp         = ctrl_q.alu_op;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign PCSource      = ctrl_q.pc_source;
  assign RegDst        = ctrl_q.reg_dst;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign IorD          = ctrl_q.ior_d;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign MemRead       = ctrl_q.mem_read      & enable;
  assign MemWrite      = ctrl_q.mem_write     & enable;
  assign RegWrite      = ctrl_q.reg_write     & enable;
  assign IRWrite       = ctrl_q.ir_write      & enable;
  assign PCWrite       = ctrl_q.pc_write      & enable;
  assign PCWriteCond   = ctrl_q.pc_write_cond & enable;
  assign state         = state_q;
  assign halted        = halted_q;
  assign illegal_op    = illegal_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Testbench for main_control_fsm. It follows MEM_WAIT_EN when the macro is defined.
module tb_main_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  opcode;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic        RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite;
  logic        IRWrite, PCWrite, PCWriteCond, ALUSrcA;
  logic [3:0]  state;
  logic        halted, illegal_op;
  logic [15:0] instr_retired;

  main_control_fsm dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .ALUSrcA(ALUSrcA), .state(state), .halted(halted),
    .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [3:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_cnt;
  logic        exp_ill;

  wire [15:0] obs = {ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead,
                     MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond,
                     ALUSrcA};

  // Control word expected in state s; en=0 clears the write/read strobes.
  function automatic logic [15:0] model_ctrl(input logic [3:0] s, input logic en);
    logic [1:0] aop, bsel, psrc;
    logic rd, m2r, mr, mw, iord, rw, irw, pcw, pcwc, asa;
    {aop, bsel, psrc} = '0;
    {rd, m2r, mr, mw, iord, rw, irw, pcw, pcwc, asa} = '0;
    case (s)
      4'd0: begin
        mr = 1'b1;
        if (!WAIT_MODE) begin irw = 1'b1; pcw = 1'b1; bsel = 2'b01; end
      end
      4'd1:  begin mr = 1'b1; irw = 1'b1; pcw = 1'b1; bsel = 2'b01; end
      4'd2:  bsel = 2'b11;
      4'd3:  begin asa = 1'b1; bsel = 2'b10; end
      4'd4, 4'd5: begin mr = 1'b1; iord = 1'b1; end
      4'd6:  begin rw = 1'b1; m2r = 1'b1; iord = 1'b1; mr = 1'b1; end
      4'd7:  begin mw = 1'b1; iord = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b10; end
      4'd9:  begin rw = 1'b1; rd = 1'b1; end
      4'd10: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd11: begin pcw = 1'b1; psrc = 2'b10; end
      4'd12: begin asa = 1'b1; bsel = 2'b10; end
      4'd13: rw = 1'b1;
      default: ;
    endcase
    if (!en) begin mr = 1'b0; mw = 1'b0; rw = 1'b0; irw = 1'b0; pcw = 1'b0; pcwc = 1'b0; end
    return {aop, bsel, psrc, rd, m2r, mr, mw, iord, rw, irw, pcw, pcwc, asa};
  endfunction

  // Expected state walk for one instruction, excluding the FETCH that follows it.
  task automatic push_seq(input logic [2:0] op);
    exp_q.push_back(4'd0);
    if (WAIT_MODE) exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    case (op)
      3'b000: begin exp_q.push_back(4'd8); exp_q.push_back(4'd9); end
      3'b001: begin
        exp_q.push_back(4'd3); exp_q.push_back(4'd4);
        if (WAIT_MODE) exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
      end
      3'b010: begin exp_q.push_back(4'd3); exp_q.push_back(4'd7); end
      3'b011: exp_q.push_back(4'd10);
      3'b100: exp_q.push_back(4'd11);
      3'b101: begin exp_q.push_back(4'd12); exp_q.push_back(4'd13); end
      3'b111: exp_q.push_back(4'd14);
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction starting from FETCH. If stall_at names a state,
  // enable is dropped for 3 cycles when that state is first reached.
  task automatic drive_instr(input logic [2:0] op, input logic [3:0] stall_at);
    logic [3:0] e;
    opcode = op;
    push_seq(op);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e == stall_at) begin
        enable = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          total++;
          if (state !== e || obs !== model_ctrl(e, 1'b0)) begin
            bad++;
            $display("FAIL stall op=%b got state=%0d ctrl=%h want state=%0d ctrl=%h",
                     op, state, obs, e, model_ctrl(e, 1'b0));
          end
          step();
        end
        enable = 1'b1;
        #1;
      end
      total++;
      if (state !== e) begin
        bad++;
        $display("FAIL state op=%b got %0d want %0d", op, state, e);
      end
      total++;
      if (obs !== model_ctrl(e, 1'b1)) begin
        bad++;
        $display("FAIL ctrl op=%b state=%0d got %h want %h", op, e, obs, model_ctrl(e, 1'b1));
      end
      total++;
      if (halted !== (e == 4'd14)) begin
        bad++;
        $display("FAIL halted state=%0d got %b want %b", e, halted, (e == 4'd14));
      end
      if (e != 4'd14) step();
    end
    if (op != 3'b111) begin
      exp_cnt = exp_cnt + 16'd1;
      if (op == 3'b110) exp_ill = 1'b1;
      total++;
      if (state !== 4'd0) begin
        bad++;
        $display("FAIL return op=%b got state %0d want 0", op, state);
      end
    end
    total++;
    if (instr_retired !== exp_cnt) begin
      bad++;
      $display("FAIL count op=%b got %h want %h", op, instr_retired, exp_cnt);
    end
    total++;
    if (illegal_op !== exp_ill) begin
      bad++;
      $display("FAIL illegal op=%b got %b want %b", op, illegal_op, exp_ill);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; opcode = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    exp_cnt = 16'd0; exp_ill = 1'b0;
    total++;
    if (state !== 4'd0 || instr_retired !== 16'd0 || illegal_op !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset got state=%0d cnt=%h ill=%b halt=%b want 0/0000/0/0",
               state, instr_retired, illegal_op, halted);
    end
    total++;
    if (obs !== model_ctrl(4'd0, 1'b1)) begin
      bad++;
      $display("FAIL reset_ctrl got %h want %h", obs, model_ctrl(4'd0, 1'b1));
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_instr_mix();
    drive_instr(3'b000, 4'hF);  // R-type: count becomes 1
    drive_instr(3'b001, 4'hF);  // LW
    drive_instr(3'b011, 4'hF);  // BEQ
    drive_instr(3'b100, 4'hF);  // J
    drive_instr(3'b101, 4'hF);  // ADDI
  endtask

  task automatic test_stall();
    drive_instr(3'b010, 4'd7);  // SW stalled in MWR
    drive_instr(3'b001, 4'd2);  // LW stalled in DECODE
  endtask

  task automatic test_illegal();
    drive_instr(3'b110, 4'hF);
    drive_instr(3'b000, 4'hF);  // flag must persist
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 5));
      drive_instr(op, 4'hF);
    end
  endtask

  task automatic test_wrap();
    // Preload the counter just below the wrap point instead of retiring 65534 instructions.
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    exp_cnt = 16'hFFFE;
    drive_instr(3'b100, 4'hF);  // -> FFFF
    drive_instr(3'b100, 4'hF);  // -> 0000
  endtask

  task automatic test_reset_mid();
    int guard;
    opcode = 3'b010;
    guard = 0;
    while (state !== 4'd7 && guard < 10) begin
      step();
      guard++;
    end
    total++;
    if (state !== 4'd7) begin
      bad++;
      $display("FAIL reach_mwr got state %0d want 7", state);
    end
    reset = 1'b1;
    #1;
    exp_cnt = 16'd0; exp_ill = 1'b0;
    total++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || instr_retired !== 16'd0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got state=%0d memwr=%b cnt=%h ill=%b want 0/0/0000/0",
               state, MemWrite, instr_retired, illegal_op);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_halt();
    drive_instr(3'b000, 4'hF);
    drive_instr(3'b111, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (state !== 4'd14 || halted !== 1'b1 || instr_retired !== exp_cnt ||
          obs !== model_ctrl(4'd14, 1'b1)) begin
        bad++;
        $display("FAIL halt_hold got state=%0d halt=%b cnt=%h ctrl=%h want 14/1/%h/%h",
                 state, halted, instr_retired, obs, exp_cnt, model_ctrl(4'd14, 1'b1));
      end
    end
    reset = 1'b1;
    #1;
    total++;
    if (state !== 4'd0 || halted !== 1'b0 || instr_retired !== 16'd0) begin
      bad++;
      $display("FAIL halt_reset got state=%0d halt=%b cnt=%h want 0/0/0000",
               state, halted, instr_retired);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_cnt = 16'd0; exp_ill = 1'b0;
    drive_instr(3'b100, 4'hF);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_instr_mix();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
